nonce_sweep_ctrl: RTL and testbench



---
 rtl/sweep_pkg.sv | 27 ++
 rtl/hash_word_cmp.sv | 25 ++
 rtl/nonce_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_pkg
// Description : Shared types and constants for the nonce sweep controller.
//               Holds the state encoding, the number of hash words read
//               back per nonce and the 32-bit word type.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

  localparam int HASH_WORDS = 8;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_NONCE = 3'd1,
    KICK     = 3'd2,
    ARM      = 3'd3,
    WAIT     = 3'd4,
    RD_ADDR  = 3'd5,
    RD_CMP   = 3'd6,
    NEXT     = 3'd7
  } state_t;

endpackage : sweep_pkg
`default_nettype wire

// File: rtl/hash_word_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hash_word_cmp
// Description : Unsigned compare of one 32-bit hash word against one target
//               word. Purely combinational.
// Ports       : a  - hash word read from memory
//               b  - target word
//               lt - a < b
//               gt - a > b   (both low means equal)
// Revision    : 1.0 - initial release
// ============================================================================
module hash_word_cmp
  import sweep_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output logic  lt,
  output logic  gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule : hash_word_cmp
`default_nettype wire

// File: rtl/nonce_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nonce_sweep_ctrl
// Description : Bitcoin nonce-search loop around a 20-word SHA-256 core.
//               For each nonce: write it into the header, kick the core,
//               wait for it, read back h0..h7 and compare (MSW first,
//               unsigned) against the target. Stops at the first hash that
//               is strictly below the target or when the range runs out.
// Ports       : clk/reset        - clock, synchronous active-high reset
//               start            - launch a sweep (sampled in IDLE only)
//               header_addr      - word address of header word 0
//               hash_addr        - word address of h0 written by the core
//               nonce_base       - first nonce tried
//               target           - 256-bit threshold, [255:224] vs h0
//               core_start       - one-cycle start pulse to the core
//               core_done        - core idle level
//               core_sel         - core owns the memory port
//               mem_*            - memory port (read data one cycle late)
//               done             - high while idle
//               found            - last sweep hit
//               found_nonce      - winning nonce, else last nonce tried
//               win_hash         - hash of the winning nonce (option only)
// Option      : NONCE_SWEEP_HASH_CAPTURE_EN - always read all eight words,
//               latch the decision at the first differing word and capture
//               the winning hash on win_hash.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20,
  parameter int NONCE_IDX    = 19,
  parameter int NUM_NONCES   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  header_addr,
  input  logic [15:0]  hash_addr,
  input  logic [31:0]  nonce_base,
  input  logic [255:0] target,
  output logic         core_start,
  input  logic         core_done,
  output logic         core_sel,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
  ,
  output logic [255:0] win_hash
`endif
);

  // Keep the nonce inside the header even if the parameters disagree.
  localparam int          NONCE_OFS = (NONCE_IDX < NUM_OF_WORDS) ? NONCE_IDX : NUM_OF_WORDS - 1;
  localparam logic [15:0] LAST_CNT  = 16'(NUM_NONCES - 1);
  localparam logic [2:0]  LAST_WORD = 3'(HASH_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  word_t       nonce;
  logic [15:0] cnt;
  logic [2:0]  k;

  word_t       tgt_word;
  logic        cmp_lt;
  logic        cmp_gt;
  logic        last_word;
  logic        last_nonce;
  logic        rd_hit;
  logic        rd_next;

  assign mem_clk = clk;

  // Word k of the target, word 0 being the most significant: (7-k)*32.
  assign tgt_word = target[{~k, 5'b00000} +: 32];

  hash_word_cmp u_cmp (
    .a  (mem_read_data),
    .b  (tgt_word),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  assign last_word  = (k == LAST_WORD);
  assign last_nonce = (cnt == LAST_CNT);

`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
  logic         decided;
  logic         dec_lt;
  logic [255:0] shadow;
  logic         hit_now;

  // Once a word differs the verdict is frozen; later words only fill shadow.
  assign hit_now = decided ? dec_lt : cmp_lt;
  assign rd_hit  = last_word & hit_now;
  assign rd_next = last_word & ~hit_now;
`else
  // Early exit at the first differing word; full equality is a miss.
  assign rd_hit  = cmp_lt;
  assign rd_next = ~cmp_lt & (cmp_gt | last_word);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    core_start     = 1'b0;
    core_sel       = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        done = 1'b1;
        if (start) state_nxt = WR_NONCE;
      end
      WR_NONCE: begin
        mem_we         = 1'b1;
        mem_addr       = header_addr + 16'(NONCE_OFS);
        mem_write_data = nonce;
        state_nxt      = KICK;
      end
      KICK: begin
        core_start = 1'b1;
        core_sel   = 1'b1;
        state_nxt  = ARM;
      end
      ARM: begin
        // core_done may still read high here; the core drops it a cycle late.
        core_sel  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        core_sel = 1'b1;
        if (core_done) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        mem_addr  = hash_addr + {13'd0, k};
        state_nxt = RD_CMP;
      end
      RD_CMP: begin
        if (rd_hit)       state_nxt = IDLE;
        else if (rd_next) state_nxt = NEXT;
        else              state_nxt = RD_ADDR;
      end
      NEXT: begin
        state_nxt = last_nonce ? IDLE : WR_NONCE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nonce       <= 32'd0;
      cnt         <= 16'd0;
      k           <= 3'd0;
      found       <= 1'b0;
      found_nonce <= 32'd0;
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
      decided     <= 1'b0;
      dec_lt      <= 1'b0;
      shadow      <= 256'd0;
      win_hash    <= 256'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nonce <= nonce_base;
            cnt   <= 16'd0;
            found <= 1'b0;
          end
        end
        WAIT: begin
          if (core_done) begin
            k <= 3'd0;
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
            decided <= 1'b0;
            dec_lt  <= 1'b0;
`endif
          end
        end
        RD_CMP: begin
          if (rd_hit) begin
            found       <= 1'b1;
            found_nonce <= nonce;
          end else if (!rd_next) begin
            k <= k + 3'd1;
          end
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
          shadow <= {shadow[223:0], mem_read_data};
          if (!decided && (cmp_lt || cmp_gt)) begin
            decided <= 1'b1;
            dec_lt  <= cmp_lt;
          end
          if (rd_hit) win_hash <= {shadow[223:0], mem_read_data};
`endif
        end
        NEXT: begin
          found_nonce <= nonce;
          if (!last_nonce) begin
            nonce <= nonce + 32'd1;
            cnt   <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : nonce_sweep_ctrl
`default_nettype wire

// File: tb/tb_nonce_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_sweep_ctrl
// Description : Scoreboard bench for nonce_sweep_ctrl. A behavioural SHA core
//               and word memory stand in for the real core; the driver
//               pushes expected header writes and sweep results, a monitor
//               pops and compares them as the DUT produces them.
// Option      : NONCE_SWEEP_HASH_CAPTURE_EN selects the capture expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_sweep_ctrl;

  localparam logic [15:0] HDR  = 16'h0040;
  localparam logic [15:0] HASH = 16'h0100;
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam logic [255:0] H_MODE0 = {32'h00000001, 32'h11111111, 32'h22222222, 32'h33333333,
                                      32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  localparam logic [255:0] T_EQ    = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978,
                                      32'h87969594, 32'hA3B2C1D0, 32'hDEADBEEF, 32'h00000010};
  localparam logic [255:0] H_WIN5  = {32'h00000000, 32'hCAFEF00D, 32'h0BADBEEF, 32'h01020304,
                                      32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  nonce_base = 32'd0;
  logic [255:0] cur_tgt = 256'd0;
  logic         core_start, core_sel, mem_clk, mem_we, done, found;
  logic         core_done = 1'b1;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data, found_nonce;
  logic [31:0]  mem_read_data = 32'd0;
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
  logic [255:0] win_hash;
`endif

  logic         core_wr_en = 1'b0;
  logic [9:0]   core_wr_addr = 10'd0;
  logic [31:0]  core_wr_data = 32'd0;
  logic [31:0]  mem [0:1023];

  int           cur_mode = 0;
  logic [31:0]  cur_base = 32'd0;
  int           n_cmp = 0;
  int           n_err = 0;

  typedef struct {
    logic         f;
    logic [31:0]  nonce;
    int           starts;
    int           reads;
    logic [255:0] hash;
  } sweep_t;

  logic [31:0] exp_wr[$];
  sweep_t      exp_sw[$];

  always #5 clk = ~clk;

  nonce_sweep_ctrl #(
    .NUM_OF_WORDS (20),
    .NONCE_IDX    (19),
    .NUM_NONCES   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .header_addr    (HDR),
    .hash_addr      (HASH),
    .nonce_base     (nonce_base),
    .target         (cur_tgt),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_sel       (core_sel),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .done           (done),
    .found          (found),
    .found_nonce    (found_nonce)
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
    ,
    .win_hash       (win_hash)
`endif
  );

  // Shared word memory behind the core_sel mux.
  always @(posedge clk) begin
    if (core_sel) begin
      if (core_wr_en) mem[core_wr_addr] <= core_wr_data;
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_write_data;
    end
    mem_read_data <= mem[mem_addr[9:0]];
  end

  function automatic logic [255:0] hash_of(input int m, input logic [31:0] n);
    case (m)
      0:       return H_MODE0;
      2:       return cur_tgt - 256'd1;
      3:       return cur_tgt;
      5:       return (n == cur_base + 32'd2) ? H_WIN5 : {256{1'b1}};
      default: return {256{1'b1}};
    endcase
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural core: keeps done high through the cycle after start, then
  // hashes the nonce found in header word 19 and writes h0..h7.
  initial begin
    logic [255:0] h;
    logic [31:0]  n;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && !reset) begin
        @(negedge clk);
        @(negedge clk);
        core_done = 1'b0;
        n = mem[HDR[9:0] + 10'd19];
        h = hash_of(cur_mode, n);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          core_wr_en   = 1'b1;
          core_wr_addr = HASH[9:0] + 10'(i);
          core_wr_data = h[255 - 32*i -: 32];
          @(negedge clk);
        end
        core_wr_en = 1'b0;
        core_done  = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT writes a nonce or finishes.
  initial begin
    int     starts = 0;
    int     reads  = 0;
    logic   prev_done = 1'b1;
    sweep_t e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        starts    = 0;
        reads     = 0;
        prev_done = done;
      end else begin
        if (mem_we) begin
          check("we_while_core_sel", 256'(core_sel), 256'd0);
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got %0h required none", mem_write_data);
          end else begin
            w = exp_wr.pop_front();
            check("nonce_wr_data", 256'(mem_write_data), 256'(w));
            check("nonce_wr_addr", 256'(mem_addr), 256'(HDR + 16'd19));
          end
        end
        if (core_start) starts++;
        if (!done && !mem_we && !core_sel && mem_addr >= HASH && mem_addr < HASH + 16'd8)
          reads++;
        if (done && !prev_done) begin
          if (exp_sw.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_sweep_end: got found_nonce %0h required none", found_nonce);
          end else begin
            e = exp_sw.pop_front();
            check("found", 256'(found), 256'(e.f));
            check("found_nonce", 256'(found_nonce), 256'(e.nonce));
            check("core_start_count", 256'(starts), 256'(e.starts));
            check("word_reads", 256'(reads), 256'(e.reads));
`ifdef NONCE_SWEEP_HASH_CAPTURE_EN
            if (e.f) check("win_hash", win_hash, e.hash);
`endif
          end
          starts = 0;
          reads  = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic push_sweep(input logic f, input logic [31:0] n, input int s, input int r,
                            input logic [255:0] h);
    sweep_t e;
    e.f = f; e.nonce = n; e.starts = s; e.reads = r; e.hash = h;
    exp_sw.push_back(e);
  endtask

  task automatic push_writes(input logic [31:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_wr.push_back(base + 32'(i));
  endtask

  task automatic wait_core_idle();
    int t = 0;
    while (!core_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!core_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL core_idle_timeout: got core_done 0 required 1");
    end
  endtask

  task automatic launch(input int m, input logic [31:0] base, input logic [255:0] tgt);
    wait_core_idle();
    cur_mode   = m;
    cur_base   = base;
    nonce_base = base;
    cur_tgt    = tgt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sweep();
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL sweep_timeout: got done 0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic wait_core_busy();
    int t = 0;
    while (core_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (core_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL core_busy_timeout: got core_done 1 required 0");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_done", 256'(done), 256'd1);
    check("rst_core_start", 256'(core_start), 256'd0);
    check("rst_core_sel", 256'(core_sel), 256'd0);
    check("rst_mem_we", 256'(mem_we), 256'd0);
    check("rst_mem_addr", 256'(mem_addr), 256'd0);
    check("rst_mem_wdata", 256'(mem_write_data), 256'd0);
    check("rst_found", 256'(found), 256'd0);
    check("rst_found_nonce", 256'(found_nonce), 256'd0);
    reset = 1'b0;
    @(negedge clk);

    // Hit on the first nonce: h0=1 below target word 0 = 2.
    push_writes(32'd5, 1);
    push_sweep(1'b1, 32'd5, 1, CAP ? 8 : 1, H_MODE0);
    launch(0, 32'd5, {32'h00000002, 224'd0});
    wait_sweep();

    // Exhaust the range: every hash is all ones, target is far below.
    push_writes(32'd5, 4);
    push_sweep(1'b0, 32'd8, 4, CAP ? 32 : 4, 256'd0);
    launch(1, 32'd5, {32'h0000FFFF, {224{1'b1}}});
    wait_sweep();

    // h0..h6 equal the target, h7 one below: hit after all eight words.
    push_writes(32'h100, 1);
    push_sweep(1'b1, 32'h100, 1, 8, T_EQ - 256'd1);
    launch(2, 32'h100, T_EQ);
    wait_sweep();

    // Full equality never hits.
    push_writes(32'h200, 4);
    push_sweep(1'b0, 32'h203, 4, 32, 256'd0);
    launch(3, 32'h200, T_EQ);
    wait_sweep();

    // Nonce wraps 0xFFFFFFFF -> 0.
    exp_wr.push_back(32'hFFFFFFFE);
    exp_wr.push_back(32'hFFFFFFFF);
    exp_wr.push_back(32'h00000000);
    exp_wr.push_back(32'h00000001);
    push_sweep(1'b0, 32'h00000001, 4, CAP ? 32 : 4, 256'd0);
    launch(4, 32'hFFFFFFFE, 256'd0);
    wait_sweep();

    // Hit on the third nonce, with a stray start pulse mid-sweep.
    push_writes(32'h1000, 3);
    push_sweep(1'b1, 32'h1002, 3, CAP ? 24 : 3, H_WIN5);
    launch(5, 32'h1000, {32'h80000000, 224'd0});
    wait_core_busy();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sweep();
    check("found_hold", 256'(found), 256'd1);
    check("found_nonce_hold", 256'(found_nonce), 256'h1002);

    // Reset while the DUT waits on the core.
    push_writes(32'h3000, 1);
    launch(5, 32'h3000, {32'h80000000, 224'd0});
    wait_core_busy();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_core_sel", 256'(core_sel), 256'd0);
    check("mid_rst_mem_we", 256'(mem_we), 256'd0);
    check("mid_rst_done", 256'(done), 256'd1);
    check("mid_rst_found", 256'(found), 256'd0);
    reset = 1'b0;
    @(negedge clk);

    // Recovery sweep after the abort.
    push_writes(32'd7, 1);
    push_sweep(1'b1, 32'd7, 1, CAP ? 8 : 1, H_MODE0);
    launch(0, 32'd7, {32'h00000002, 224'd0});
    wait_sweep();

    repeat (4) @(negedge clk);
    check("wr_queue_drained", 256'(exp_wr.size()), 256'd0);
    check("sweep_queue_drained", 256'(exp_sw.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nonce_sweep_ctrl
`default_nettype wire
